// File: rtl/jt12_timers.sv
// FM timer block: 10-bit timer A and prescaled 8-bit timer B with status flags and IRQ.
// Timer B advances once per PRESCALE_B timer ticks; flags are sticky until cleared.
module jt12_timers #(
    parameter int PRESCALE_B = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       zero,
    input  logic       fast_timers,
    input  logic [9:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       enable_irq_A,
    input  logic       enable_irq_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n
);

    localparam int PW = (PRESCALE_B > 1) ? $clog2(PRESCALE_B) : 1;

    logic [9:0]    cnt_A_q, cnt_A_d;
    logic [7:0]    cnt_B_q, cnt_B_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_A_q, run_A_d;
    logic          run_B_q, run_B_d;
    logic          flag_A_q, flag_A_d;
    logic          flag_B_q, flag_B_d;
    logic          ovf_A_q, ovf_A_d;
    logic          tick;

    assign tick = clk_en & (fast_timers | zero);

    always_comb begin
        cnt_A_d  = cnt_A_q;
        cnt_B_d  = cnt_B_q;
        presc_d  = presc_q;
        run_A_d  = run_A_q;
        run_B_d  = run_B_q;
        flag_A_d = flag_A_q;
        flag_B_d = flag_B_q;
        ovf_A_d  = ovf_A_q;
        if (clk_en) begin
            ovf_A_d = 1'b0;
            // Clears are applied first so that a same-cycle overflow set wins.
            if (clr_flag_A) flag_A_d = 1'b0;
            if (clr_flag_B) flag_B_d = 1'b0;

            if (load_A) begin
                cnt_A_d = value_A;
                run_A_d = 1'b1;
            end else if (tick && run_A_q) begin
                if (cnt_A_q == 10'h3FF) begin
                    cnt_A_d = value_A;
                    ovf_A_d = 1'b1;
                    if (enable_irq_A) flag_A_d = 1'b1;
                end else begin
                    cnt_A_d = cnt_A_q + 10'd1;
                end
            end

            if (load_B) begin
                cnt_B_d = value_B;
                presc_d = '0;
                run_B_d = 1'b1;
            end else if (tick && run_B_q) begin
                presc_d = presc_q + 1'b1;
                // All-ones means this tick wraps the power-of-two prescaler to zero.
                if (&presc_q) begin
                    if (cnt_B_q == 8'hFF) begin
                        cnt_B_d = value_B;
                        if (enable_irq_B) flag_B_d = 1'b1;
                    end else begin
                        cnt_B_d = cnt_B_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_A_q  <= '0;
            cnt_B_q  <= '0;
            presc_q  <= '0;
            run_A_q  <= 1'b0;
            run_B_q  <= 1'b0;
            flag_A_q <= 1'b0;
            flag_B_q <= 1'b0;
            ovf_A_q  <= 1'b0;
        end else begin
            cnt_A_q  <= cnt_A_d;
            cnt_B_q  <= cnt_B_d;
            presc_q  <= presc_d;
            run_A_q  <= run_A_d;
            run_B_q  <= run_B_d;
            flag_A_q <= flag_A_d;
            flag_B_q <= flag_B_d;
            ovf_A_q  <= ovf_A_d;
        end
    end

    assign flag_A     = flag_A_q;
    assign flag_B     = flag_B_q;
    assign overflow_A = ovf_A_q;
    assign irq_n      = ~(flag_A_q | flag_B_q);

endmodule

// File: tb/tb_jt12_timers.sv
// Directed bench for jt12_timers: timer A/B periods, flag set/clear priority, load priority, reset.
module tb_jt12_timers;

    logic       clk = 1'b0;
    logic       rst, clk_en, zero, fast_timers;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B;
    logic       flag_A, flag_B, overflow_A, irq_n;

    int errors = 0;
    int checks = 0;

    jt12_timers #(.PRESCALE_B(16)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .fast_timers(fast_timers),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; zero = 1'b0; fast_timers = 1'b0;
        value_A = '0; value_B = '0; load_A = 1'b0; load_B = 1'b0;
        enable_irq_A = 1'b0; enable_irq_B = 1'b0; clr_flag_A = 1'b0; clr_flag_B = 1'b0;
        cyc(); cyc();
        chk("rst_flag_A", flag_A, 0);
        chk("rst_flag_B", flag_B, 0);
        chk("rst_ovf_A", overflow_A, 0);
        chk("rst_irq_n", irq_n, 1);
        rst = 1'b0;
        cyc();
        chk("idle_ovf_A", overflow_A, 0);

        // Timer A, value 1020, zero every 24 clk_en: overflow on every 4th zero
        value_A = 10'd1020; enable_irq_A = 1'b1; load_A = 1'b1;
        cyc();
        load_A = 1'b0;
        chk("t1_load_ovf", overflow_A, 0);
        for (int k = 0; k < 8; k++) begin
            zero = 1'b1;
            cyc();
            zero = 1'b0;
            chk("t1_ovf", overflow_A, (k % 4 == 3) ? 1 : 0);
            chk("t1_flag_A", flag_A, (k >= 3) ? 1 : 0);
            chk("t1_irq_n", irq_n, (k >= 3) ? 0 : 1);
            cyc();
            chk("t1_ovf_clear", overflow_A, 0);
            repeat (22) cyc();
        end

        // Set and clear on the same overflowing clk_en: set wins
        clr_flag_A = 1'b1;
        cyc();
        clr_flag_A = 1'b0;
        chk("t4_pre_clr_flag", flag_A, 0);
        chk("t4_pre_clr_irq", irq_n, 1);
        for (int k = 0; k < 3; k++) begin
            zero = 1'b1;
            cyc();
            zero = 1'b0;
            chk("t4_no_ovf", overflow_A, 0);
            cyc();
        end
        zero = 1'b1; clr_flag_A = 1'b1;
        cyc();
        zero = 1'b0; clr_flag_A = 1'b0;
        chk("t4_set_wins_flag", flag_A, 1);
        chk("t4_set_wins_ovf", overflow_A, 1);
        chk("t4_set_wins_irq", irq_n, 0);
        clr_flag_A = 1'b1;
        cyc();
        clr_flag_A = 1'b0;
        chk("t4_clr_flag", flag_A, 0);
        chk("t4_clr_irq", irq_n, 1);

        // Value change without load: current period still ends 4 ticks later, then 24-tick periods
        value_A = 10'd1000; fast_timers = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            cyc();
            chk("t6_ovf", overflow_A, (i == 4 || i == 28) ? 1 : 0);
        end
        fast_timers = 1'b0; clr_flag_A = 1'b1;
        cyc();
        clr_flag_A = 1'b0;
        chk("t6_clr_flag", flag_A, 0);

        // value_A=1023 without IRQ enable: overflow on every zero, no flag
        value_A = 10'd1023; enable_irq_A = 1'b0; load_A = 1'b1;
        cyc();
        load_A = 1'b0;
        for (int k = 0; k < 4; k++) begin
            zero = 1'b1;
            cyc();
            zero = 1'b0;
            chk("t2_ovf", overflow_A, 1);
            chk("t2_flag_A", flag_A, 0);
            chk("t2_irq_n", irq_n, 1);
            cyc();
            chk("t2_ovf_clear", overflow_A, 0);
        end

        // Load beats a same-cycle tick that would otherwise overflow
        value_A = 10'd1020; load_A = 1'b1;
        cyc();
        load_A = 1'b0; zero = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_count_ovf", overflow_A, 0);
        end
        load_A = 1'b1;
        cyc();
        load_A = 1'b0;
        chk("t5_load_vs_tick", overflow_A, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("t5_after_reload", overflow_A, (k == 4) ? 1 : 0);
        end
        zero = 1'b0;
        cyc();

        // Timer B, value 254: flag after 32 ticks (fast_timers)
        value_B = 8'd254; enable_irq_B = 1'b1; load_B = 1'b1;
        cyc();
        load_B = 1'b0; fast_timers = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            chk("t3_flag_B", flag_B, (i == 32) ? 1 : 0);
            chk("t3_irq_n", irq_n, (i == 32) ? 0 : 1);
        end
        chk("t3_flag_A_off", flag_A, 0);

        // No state change while clk_en is low
        fast_timers = 1'b0; clk_en = 1'b0; clr_flag_B = 1'b1;
        cyc(); cyc();
        chk("gate_flag_B", flag_B, 1);
        clk_en = 1'b1;
        cyc();
        clr_flag_B = 1'b0;
        chk("clr_flag_B", flag_B, 0);
        chk("clr_irq_n", irq_n, 1);

        // Reset mid-count stops both timers
        fast_timers = 1'b1; enable_irq_A = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_rst_flag_A", flag_A, 0);
        chk("t5_rst_flag_B", flag_B, 0);
        chk("t5_rst_ovf", overflow_A, 0);
        chk("t5_rst_irq", irq_n, 1);
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("post_rst_ovf", overflow_A, 0);
            chk("post_rst_irq", irq_n, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
